// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and sizing for the register-file write arbiter.
// Slot payloads and round-robin pointer helpers live here.
package rf_write_arbiter_pkg;

    localparam int NUM_SRC    = 4;
    localparam int NUM_P_REGS = 64;
    localparam int WORD_SIZE  = 32;
    localparam int PREG_W     = $clog2(NUM_P_REGS);
    localparam int PTR_W      = $clog2(NUM_SRC);

    typedef logic [PREG_W-1:0]    preg_t;
    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [PTR_W-1:0]     ptr_t;

    typedef struct packed {
        preg_t dest;
        word_t word;
    } wb_req_t;

    // Modulo-NUM_SRC increment, safe for non-power-of-two source counts.
    function automatic ptr_t ptr_inc(ptr_t p);
        if (int'(p) == NUM_SRC - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback-source handshake bundle: one valid/ready lane per source.
// Sources drive the master side, the arbiter sits on the slave side.
interface rf_write_arbiter_if;
    import rf_write_arbiter_pkg::*;

    logic    [NUM_SRC-1:0] valid;
    logic    [NUM_SRC-1:0] ready;
    wb_req_t [NUM_SRC-1:0] req;

    modport master (
        output valid,
        output req,
        input  ready
    );

    modport slave (
        input  valid,
        input  req,
        output ready
    );

endinterface

// File: rtl/rf_write_arbiter_rr_pick2.sv
// Combinational two-port round-robin picker over the holding slots.
// The second grant is withheld when it would alias the first grant's dest.
module rr_pick2
    import rf_write_arbiter_pkg::*;
(
    input  logic                  [NUM_SRC-1:0] req_i,
    input  ptr_t                                rr_ptr_i,
    input  preg_t                 [NUM_SRC-1:0] dest_i,
    output logic                  [NUM_SRC-1:0] gnt0_o,
    output logic                  [NUM_SRC-1:0] gnt1_o,
    output logic                                v0_o,
    output logic                                v1_o,
    output ptr_t                                idx0_o,
    output ptr_t                                idx1_o
);

    ptr_t  idx;
    preg_t d0;
    logic  done;

    always_comb begin
        gnt0_o = '0;
        gnt1_o = '0;
        v0_o   = 1'b0;
        v1_o   = 1'b0;
        idx0_o = '0;
        idx1_o = '0;
        d0     = '0;
        done   = 1'b0;
        idx    = rr_ptr_i;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_i[idx] && !done) begin
                if (!v0_o) begin
                    v0_o        = 1'b1;
                    gnt0_o[idx] = 1'b1;
                    idx0_o      = idx;
                    d0          = dest_i[idx];
                end else begin
                    // Only the very next hit may take port 1.
                    done = 1'b1;
                    if (dest_i[idx] != d0) begin
                        v1_o        = 1'b1;
                        gnt1_o[idx] = 1'b1;
                        idx1_o      = idx;
                    end
                end
            end
            idx = ptr_inc(idx);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Funnels NUM_SRC writeback results through one-entry slots onto two RF
// write ports; writes to p0 are silently dropped.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    rf_write_arbiter_if.slave   src,
    output logic                reg_write0_o,
    output preg_t               dest0_o,
    output word_t               word0_o,
    output logic                reg_write1_o,
    output preg_t               dest1_o,
    output word_t               word1_o,
    output logic                busy_o
);

    logic    [NUM_SRC-1:0] hold_v;
    wb_req_t [NUM_SRC-1:0] hold;
    ptr_t                  rr_ptr;

    preg_t   [NUM_SRC-1:0] slot_dest;
    logic    [NUM_SRC-1:0] live;
    logic    [NUM_SRC-1:0] drop;
    logic    [NUM_SRC-1:0] drain;
    logic    [NUM_SRC-1:0] acc;
    logic    [NUM_SRC-1:0] gnt0;
    logic    [NUM_SRC-1:0] gnt1;
    logic                  v0;
    logic                  v1;
    ptr_t                  idx0;
    ptr_t                  idx1;

    always_comb begin
        slot_dest = '0;
        live      = '0;
        drop      = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            slot_dest[s] = hold[s].dest;
            live[s]      = hold_v[s] && (hold[s].dest != '0);
            drop[s]      = hold_v[s] && (hold[s].dest == '0);
        end
    end

    rr_pick2 u_pick (
        .req_i    (live),
        .rr_ptr_i (rr_ptr),
        .dest_i   (slot_dest),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1),
        .v0_o     (v0),
        .v1_o     (v1),
        .idx0_o   (idx0),
        .idx1_o   (idx1)
    );

    // p0 slots free themselves without consuming a port.
    assign drain     = drop | gnt0 | gnt1;
    assign src.ready = rst_ni ? (~hold_v | drain) : '0;
    assign acc       = src.valid & src.ready;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_v <= '0;
            hold   <= '0;
            rr_ptr <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (acc[s]) begin
                    hold_v[s] <= 1'b1;
                    hold[s]   <= src.req[s];
                end else if (drain[s]) begin
                    hold_v[s] <= 1'b0;
                end
            end
            if (v0) begin
                rr_ptr <= ptr_inc(v1 ? idx1 : idx0);
            end
        end
    end

    assign reg_write0_o = rst_ni & v0;
    assign reg_write1_o = rst_ni & v1;
    assign busy_o       = rst_ni & (|hold_v);

    always_comb begin
        dest0_o = '0;
        word0_o = '0;
        dest1_o = '0;
        word1_o = '0;
        if (reg_write0_o) begin
            dest0_o = hold[idx0].dest;
            word0_o = hold[idx0].word;
        end
        if (reg_write1_o) begin
            dest1_o = hold[idx1].dest;
            word1_o = hold[idx1].word;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed cycle-exact scenarios
// followed by randomized traffic against an unordered result model.
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  rw0, rw1, busy;
    preg_t d0, d1;
    word_t x0, x1;

    always #5 clk = ~clk;

    rf_write_arbiter_if ifc ();

    rf_write_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .src          (ifc),
        .reg_write0_o (rw0),
        .dest0_o      (d0),
        .word0_o      (x0),
        .reg_write1_o (rw1),
        .dest1_o      (d1),
        .word1_o      (x1),
        .busy_o       (busy)
    );

    typedef struct {
        int    c;
        bit    w0;
        preg_t d0;
        word_t x0;
        bit    w1;
        preg_t d1;
        word_t x1;
    } exp_t;

    typedef struct {
        preg_t d;
        word_t x;
        int    c;
    } pend_t;

    exp_t                 exq[$];
    pend_t                pend[$];
    word_t                rf[NUM_P_REGS];
    logic [NUM_SRC-1:0]   acc_mask = '0;
    int                   tests = 0;
    int                   fails = 0;
    int                   cyc = 0;
    exp_t                 e;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     name, cyc, act, req);
        end
    endtask

    task automatic match(string name, preg_t d, word_t x);
        int hit;
        int age;
        hit = -1;
        foreach (pend[i]) begin
            if (hit < 0 && pend[i].d == d && pend[i].x == x) hit = i;
        end
        tests++;
        if (hit < 0) begin
            fails++;
            $display("FAIL %s unexpected write @cyc %0d: dest %0d word %0h",
                     name, cyc, d, x);
        end else begin
            age = cyc - pend[hit].c;
            check({name, "_age"}, 64'(age > NUM_SRC), 64'(0));
            pend.delete(hit);
        end
    endtask

    // Monitor: scoreboard compare, protocol rules, RF and pending bookkeeping.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ready", 64'(ifc.ready), 64'(0));
            check("rst_outs", 64'({rw0, rw1, busy}), 64'(0));
            pend.delete();
            acc_mask = '0;
        end else begin
            while (exq.size() > 0 && exq[0].c < cyc) begin
                tests++;
                fails++;
                $display("FAIL exp_missed: entry for cyc %0d unchecked at %0d",
                         exq[0].c, cyc);
                void'(exq.pop_front());
            end
            if (exq.size() > 0 && exq[0].c == cyc) begin
                e = exq.pop_front();
                check("port0", 64'({rw0, d0, x0}), 64'({e.w0, e.d0, e.x0}));
                check("port1", 64'({rw1, d1, x1}), 64'({e.w1, e.d1, e.x1}));
            end
            check("p1_without_p0", 64'(rw1 & ~rw0), 64'(0));
            if (rw0) check("p0_dest_nz", 64'(d0 != '0), 64'(1));
            else     check("p0_idle", 64'({d0, x0}), 64'(0));
            if (rw1) check("p1_dest_nz", 64'(d1 != '0), 64'(1));
            else     check("p1_idle", 64'({d1, x1}), 64'(0));
            if (rw0 && rw1) check("same_dest", 64'(d0 == d1), 64'(0));
            if (rw0) begin
                match("p0", d0, x0);
                rf[d0] = x0;
            end
            if (rw1) begin
                match("p1", d1, x1);
                rf[d1] = x1;
            end
            for (int s = 0; s < NUM_SRC; s++) begin
                if (ifc.valid[s] && ifc.ready[s] && ifc.req[s].dest != '0)
                    pend.push_back('{ifc.req[s].dest, ifc.req[s].word, cyc});
            end
            acc_mask = ifc.valid & ifc.ready;
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a posedge; offers for exactly one cycle.
    task automatic offer(logic [NUM_SRC-1:0] m, preg_t [NUM_SRC-1:0] d,
                         word_t [NUM_SRC-1:0] w, output int c);
        ifc.valid = m;
        for (int s = 0; s < NUM_SRC; s++) begin
            ifc.req[s].dest = d[s];
            ifc.req[s].word = w[s];
        end
        c = cyc;
        @(posedge clk);
        #1;
        ifc.valid = '0;
    endtask

    task automatic pexp(int c, bit a0, preg_t b0, word_t y0,
                        bit a1, preg_t b1, word_t y1);
        exq.push_back('{c, a0, b0, y0, a1, b1, y1});
    endtask

    initial begin
        preg_t [NUM_SRC-1:0] dv;
        word_t [NUM_SRC-1:0] wv;
        word_t               tag;
        int                  c;

        foreach (rf[i]) rf[i] = '0;
        rst_n     = 1'b0;
        ifc.valid = '1;
        ifc.req   = '0;

        // Reset with all sources offering.
        @(posedge clk);
        @(negedge clk);
        check("t1_ready_in_rst", 64'(ifc.ready), 64'(0));
        check("t1_wr_in_rst", 64'({rw0, rw1}), 64'(0));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ifc.valid = '0;
        @(negedge clk);
        check("t1_ready_after", 64'(ifc.ready), 64'(4'hF));
        check("t1_busy_after", 64'(busy), 64'(0));
        idle(1);

        // Contention from rr_ptr=0.
        dv = '{preg_t'(4), preg_t'(3), preg_t'(2), preg_t'(1)};
        wv = '{32'hA3, 32'hA2, 32'hA1, 32'hA0};
        offer(4'hF, dv, wv, c);
        pexp(c + 1, 1, 1, 32'hA0, 1, 2, 32'hA1);
        pexp(c + 2, 1, 3, 32'hA2, 1, 4, 32'hA3);
        @(negedge clk);
        check("t3_ready", 64'(ifc.ready), 64'(4'b0011));
        idle(2);

        // Same dest from src0 and src1.
        dv = '{preg_t'(0), preg_t'(0), preg_t'(7), preg_t'(7)};
        wv = '{32'h0, 32'h0, 32'h22, 32'h11};
        offer(4'b0011, dv, wv, c);
        pexp(c + 1, 1, 7, 32'h11, 0, 0, 0);
        pexp(c + 2, 1, 7, 32'h22, 0, 0, 0);
        @(negedge clk);
        check("t4_ready1_wait", 64'(ifc.ready[1]), 64'(0));
        idle(2);
        check("t4_rf_p7", 64'(rf[7]), 64'(32'h22));

        // Single result.
        dv = '{preg_t'(0), preg_t'(5), preg_t'(0), preg_t'(0)};
        wv = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
        offer(4'b0100, dv, wv, c);
        pexp(c + 1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0);
        idle(2);
        check("t2_rf_p5", 64'(rf[5]), 64'(32'hDEAD_BEEF));

        // Drop to p0; rr_ptr must stay at 3.
        dv = '{preg_t'(0), preg_t'(0), preg_t'(0), preg_t'(0)};
        wv = '{32'h55, 32'h0, 32'h0, 32'h0};
        offer(4'b1000, dv, wv, c);
        pexp(c + 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t5_ready3", 64'(ifc.ready[3]), 64'(1));
        idle(1);
        @(negedge clk);
        check("t5_busy", 64'(busy), 64'(0));
        idle(1);
        dv = '{preg_t'(21), preg_t'(0), preg_t'(0), preg_t'(20)};
        wv = '{32'hA3A3, 32'h0, 32'h0, 32'hA0A0};
        offer(4'b1001, dv, wv, c);
        pexp(c + 1, 1, 21, 32'hA3A3, 1, 20, 32'hA0A0);
        idle(2);

        // Reset with all four slots full.
        dv = '{preg_t'(13), preg_t'(12), preg_t'(11), preg_t'(10)};
        wv = '{32'hB3, 32'hB2, 32'hB1, 32'hB0};
        offer(4'hF, dv, wv, c);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        pexp(c + 2, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_ready", 64'(ifc.ready), 64'(4'hF));
        idle(3);
        for (int r = 10; r <= 13; r++) check("t6_rf", 64'(rf[r]), 64'(0));
        check("t6_rf_p5", 64'(rf[5]), 64'(32'hDEAD_BEEF));

        // Random traffic, valid held until accepted, one mid-run reset.
        tag = 32'h1000_0000;
        for (int i = 0; i < 3000; i++) begin
            rst_n = (i == 1500) ? 1'b0 : 1'b1;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (!ifc.valid[s] || acc_mask[s]) begin
                    if ($urandom_range(0, 99) < 70) begin
                        ifc.valid[s]    = 1'b1;
                        ifc.req[s].dest = preg_t'($urandom_range(0, 7));
                        ifc.req[s].word = tag;
                        tag             = tag + 1;
                    end else begin
                        ifc.valid[s] = 1'b0;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        ifc.valid = '0;
        idle(NUM_SRC + 4);
        check("end_pending", 64'(pend.size()), 64'(0));
        check("end_exq", 64'(exq.size()), 64'(0));
        check("end_busy", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
